// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its three neighbours:
// CPU load/store unit, external AXI-BRAM init/debug port and BRAM port A.
// slave  : view taken by the arbiter.
// master : view taken by the surrounding environment (requesters + BRAM).
interface data_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 15
);
   // CPU side
   logic              cpu_req_i;
   logic [3:0]        cpu_we_i;
   logic [31:0]       cpu_addr_i;
   logic [31:0]       cpu_wdata_i;
   logic              cpu_gnt_o;
   logic              cpu_stall_o;
   logic              cpu_rvalid_o;
   logic [31:0]       cpu_rdata_o;
   logic              cpu_misalign_o;
   // External side
   logic              ext_req_i;
   logic [3:0]        ext_we_i;
   logic [ADDR_W-1:0] ext_addr_i;
   logic [31:0]       ext_wdata_i;
   logic              ext_gnt_o;
   logic              ext_rvalid_o;
   logic [31:0]       ext_rdata_o;
   // BRAM side
   logic              mem_en_o;
   logic [3:0]        mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_din_o;
   logic [31:0]       mem_dout_i;

   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      input  ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i,
      input  mem_dout_i,
      output cpu_gnt_o, cpu_stall_o, cpu_rvalid_o, cpu_rdata_o, cpu_misalign_o,
      output ext_gnt_o, ext_rvalid_o, ext_rdata_o,
      output mem_en_o, mem_we_o, mem_addr_o, mem_din_o
   );

   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      output ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i,
      output mem_dout_i,
      input  cpu_gnt_o, cpu_stall_o, cpu_rvalid_o, cpu_rdata_o, cpu_misalign_o,
      input  ext_gnt_o, ext_rvalid_o, ext_rdata_o,
      input  mem_en_o, mem_we_o, mem_addr_o, mem_din_o
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Data-memory arbiter: shares BRAM port A between the CPU load/store unit and
// the external init/debug port. Combinational grant with fixed CPU priority,
// one-cycle read return, misaligned CPU write suppression.
// Optional build macro MEM_ARB_STARVE_GUARD_EN adds an ext starvation guard
// that forces an ext grant after STARVE_LIMIT consecutive denied cycles.
module data_mem_arbiter #(
   parameter int unsigned ADDR_W       = 15,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic                clk,
   input logic                reset,
   data_mem_arbiter_if.slave  bus
);

   logic              ext_force;
   logic              cpu_gnt;
   logic              ext_gnt;
   logic              misalign;
   logic              rd_start;
   logic              rd_owner;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din;

   logic rd_pend_q;   // a granted read returns data this cycle
   logic owner_q;     // 0: CPU owns the returning read, 1: ext
   logic misalign_q;

   // Grant, misalign detection and BRAM request mux.
   always_comb begin
      cpu_gnt  = ~reset & bus.cpu_req_i & ~ext_force;
      ext_gnt  = ~reset & bus.ext_req_i & (~bus.cpu_req_i | ext_force);
      misalign = cpu_gnt & (bus.cpu_we_i != 4'h0) & (bus.cpu_addr_i[1:0] != 2'b00);
      mem_we   = 4'h0;
      mem_addr = '0;
      mem_din  = 32'h0;
      rd_start = 1'b0;
      rd_owner = 1'b0;
      if (cpu_gnt) begin
         mem_we   = misalign ? 4'h0 : bus.cpu_we_i;
         mem_addr = bus.cpu_addr_i[ADDR_W+1:2];
         mem_din  = bus.cpu_wdata_i;
         rd_start = (bus.cpu_we_i == 4'h0);
      end else if (ext_gnt) begin
         mem_we   = bus.ext_we_i;
         mem_addr = bus.ext_addr_i;
         mem_din  = bus.ext_wdata_i;
         rd_start = (bus.ext_we_i == 4'h0);
         rd_owner = 1'b1;
      end
   end

   // Read-return pipeline and misalign pulse register.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend_q  <= 1'b0;
         owner_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         rd_pend_q  <= rd_start;
         owner_q    <= rd_start ? rd_owner : owner_q;
         misalign_q <= misalign;
      end
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
   logic [CntW-1:0] starve_cnt_q;

   // Count consecutive denied ext cycles, saturating at the limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_q <= '0;
      end else if (!bus.ext_req_i || ext_gnt) begin
         starve_cnt_q <= '0;
      end else if (starve_cnt_q != CntW'(STARVE_LIMIT)) begin
         starve_cnt_q <= starve_cnt_q + CntW'(1);
      end
   end

   assign ext_force = (starve_cnt_q == CntW'(STARVE_LIMIT));
`else
   logic unused_starve_limit;
   assign unused_starve_limit = (STARVE_LIMIT == 0);
   assign ext_force = 1'b0;
`endif

   // Upper CPU address bits are ignored: accesses wrap within the BRAM.
   logic unused_cpu_addr;
   assign unused_cpu_addr = ^bus.cpu_addr_i[31:ADDR_W+2];

   assign bus.cpu_gnt_o      = cpu_gnt;
   assign bus.ext_gnt_o      = ext_gnt;
   assign bus.cpu_stall_o    = bus.cpu_req_i & ~cpu_gnt;
   assign bus.mem_en_o       = cpu_gnt | ext_gnt;
   assign bus.mem_we_o       = mem_we;
   assign bus.mem_addr_o     = mem_addr;
   assign bus.mem_din_o      = mem_din;
   // Gating with reset cancels a read still in flight when reset arrives.
   assign bus.cpu_rvalid_o   = rd_pend_q & ~owner_q & ~reset;
   assign bus.ext_rvalid_o   = rd_pend_q & owner_q & ~reset;
   assign bus.cpu_rdata_o    = bus.cpu_rvalid_o ? bus.mem_dout_i : 32'h0;
   assign bus.ext_rdata_o    = bus.ext_rvalid_o ? bus.mem_dout_i : 32'h0;
   assign bus.cpu_misalign_o = misalign_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: a cycle-by-cycle vector table
// plus hand-written reset and contention sequences. Includes a small BRAM
// model with one-cycle read latency.
module tb_data_mem_arbiter;

   localparam int unsigned AW = 15;

   logic clk = 1'b0;
   logic reset;
   int   errs = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   data_mem_arbiter_if #(.ADDR_W(AW)) bus ();

   data_mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // BRAM model: byte writes, read data one cycle after enable.
   logic [31:0] mem [64];
   logic [31:0] dout_q;
   always @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
         dout_q <= 32'h0;
      end else if (bus.mem_en_o) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_we_o[b]) mem[bus.mem_addr_o[5:0]][8*b +: 8] <= bus.mem_din_o[8*b +: 8];
         dout_q <= mem[bus.mem_addr_o[5:0]];
      end
   end
   assign bus.mem_dout_i = dout_q;

   typedef struct {
      logic creq; logic [3:0] cwe; logic [31:0] caddr; logic [31:0] cwd;
      logic ereq; logic [3:0] ewe; logic [AW-1:0] eaddr; logic [31:0] ewd;
      logic cgnt; logic egnt; logic stall; logic en; logic [3:0] we;
      logic [AW-1:0] maddr; logic [31:0] din;
      logic crv; logic [31:0] crd; logic erv; logic [31:0] erd; logic mis;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   task automatic chk(input string name, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s (row %0d): got %h expected %h", name, row, act, exp);
      end
   endtask

   task automatic drive(input logic creq, input logic [3:0] cwe, input logic [31:0] caddr,
                        input logic [31:0] cwd, input logic ereq, input logic [3:0] ewe,
                        input logic [AW-1:0] eaddr, input logic [31:0] ewd);
      bus.cpu_req_i   = creq;
      bus.cpu_we_i    = cwe;
      bus.cpu_addr_i  = caddr;
      bus.cpu_wdata_i = cwd;
      bus.ext_req_i   = ereq;
      bus.ext_we_i    = ewe;
      bus.ext_addr_i  = eaddr;
      bus.ext_wdata_i = ewd;
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_row(input int i);
      vec_t v;
      v = vecs[i];
      chk("cpu_gnt", i, 32'(bus.cpu_gnt_o), 32'(v.cgnt));
      chk("ext_gnt", i, 32'(bus.ext_gnt_o), 32'(v.egnt));
      chk("cpu_stall", i, 32'(bus.cpu_stall_o), 32'(v.stall));
      chk("mem_en", i, 32'(bus.mem_en_o), 32'(v.en));
      chk("mem_we", i, 32'(bus.mem_we_o), 32'(v.we));
      chk("mem_addr", i, 32'(bus.mem_addr_o), 32'(v.maddr));
      chk("mem_din", i, bus.mem_din_o, v.din);
      chk("cpu_rvalid", i, 32'(bus.cpu_rvalid_o), 32'(v.crv));
      chk("cpu_rdata", i, bus.cpu_rdata_o, v.crd);
      chk("ext_rvalid", i, 32'(bus.ext_rvalid_o), 32'(v.erv));
      chk("ext_rdata", i, bus.ext_rdata_o, v.erd);
      chk("cpu_misalign", i, 32'(bus.cpu_misalign_o), 32'(v.mis));
   endtask

   initial begin
      // Inputs: creq cwe caddr cwd | ereq ewe eaddr ewd
      // Expect: cgnt egnt stall en we maddr din | crv crd erv erd mis
      vecs[0]  = '{0, 0, 0, 0,                0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0};
      vecs[1]  = '{1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0,
                   1, 0, 0, 1, 4'hF, 4, 32'hDEADBEEF,  0, 0, 0, 0, 0};
      vecs[2]  = '{0, 0, 0, 0,                1, 4'hF, 7, 32'hCAFEF00D,
                   0, 1, 0, 1, 4'hF, 7, 32'hCAFEF00D,  0, 0, 0, 0, 0};
      vecs[3]  = '{1, 0, 32'h10, 32'h55,      0, 0, 0, 0,
                   1, 0, 0, 1, 0, 4, 32'h55,           0, 0, 0, 0, 0};
      vecs[4]  = '{0, 0, 0, 0,                1, 0, 7, 0,
                   0, 1, 0, 1, 0, 7, 0,                1, 32'hDEADBEEF, 0, 0, 0};
      vecs[5]  = '{1, 0, 32'h10, 0,           1, 0, 7, 0,
                   1, 0, 0, 1, 0, 4, 0,                0, 0, 1, 32'hCAFEF00D, 0};
      vecs[6]  = '{1, 0, 32'h10, 0,           1, 0, 7, 0,
                   1, 0, 0, 1, 0, 4, 0,                1, 32'hDEADBEEF, 0, 0, 0};
      vecs[7]  = '{1, 0, 32'h10, 0,           1, 0, 7, 0,
                   1, 0, 0, 1, 0, 4, 0,                1, 32'hDEADBEEF, 0, 0, 0};
      vecs[8]  = '{0, 0, 0, 0,                1, 0, 7, 0,
                   0, 1, 0, 1, 0, 7, 0,                1, 32'hDEADBEEF, 0, 0, 0};
      vecs[9]  = '{0, 0, 0, 0,                1, 4'hF, 5, 32'h12345678,
                   0, 1, 0, 1, 4'hF, 5, 32'h12345678,  0, 0, 1, 32'hCAFEF00D, 0};
      vecs[10] = '{1, 0, 32'h14, 0,           0, 0, 0, 0,
                   1, 0, 0, 1, 0, 5, 0,                0, 0, 0, 0, 0};
      vecs[11] = '{1, 4'hF, 32'h22, 32'hFFFFFFFF, 0, 0, 0, 0,
                   1, 0, 0, 1, 0, 8, 32'hFFFFFFFF,     1, 32'h12345678, 0, 0, 0};
      vecs[12] = '{1, 0, 32'h20, 0,           0, 0, 0, 0,
                   1, 0, 0, 1, 0, 8, 0,                0, 0, 0, 0, 1};
      vecs[13] = '{0, 0, 0, 0,                0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0,                1, 0, 0, 0, 0};
      vecs[14] = '{1, 4'h3, 32'h10, 32'hAAAABBBB, 0, 0, 0, 0,
                   1, 0, 0, 1, 4'h3, 4, 32'hAAAABBBB,  0, 0, 0, 0, 0};
      vecs[15] = '{1, 0, 32'h10, 0,           0, 0, 0, 0,
                   1, 0, 0, 1, 0, 4, 0,                0, 0, 0, 0, 0};
      vecs[16] = '{0, 0, 0, 0,                0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0,                1, 32'hDEADBBBB, 0, 0, 0};
      vecs[17] = '{1, 0, 32'h20011, 0,        0, 0, 0, 0,
                   1, 0, 0, 1, 0, 4, 0,                0, 0, 0, 0, 0};
      vecs[18] = '{0, 0, 0, 0,                0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0,                1, 32'hDEADBBBB, 0, 0, 0};
      vecs[19] = '{1, 0, 32'h14, 0,           0, 0, 0, 0,
                   1, 0, 0, 1, 0, 5, 0,                0, 0, 0, 0, 0};
      vecs[20] = '{0, 0, 0, 0,                1, 0, 7, 0,
                   0, 1, 0, 1, 0, 7, 0,                1, 32'h12345678, 0, 0, 0};
      vecs[21] = '{1, 0, 32'h10, 0,           0, 0, 0, 0,
                   1, 0, 0, 1, 0, 4, 0,                0, 0, 1, 32'hCAFEF00D, 0};
      vecs[22] = '{0, 0, 0, 0,                0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0,                1, 32'hDEADBBBB, 0, 0, 0};
      vecs[23] = '{0, 0, 0, 0,                0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0};

      // Reset held with both requesters active: no grants, CPU sees a stall.
      reset = 1'b1;
      drive(1, 0, 32'h10, 0, 1, 0, 7, 0);
      step();
      step();
      #4;
      chk("rst_cpu_gnt", -1, 32'(bus.cpu_gnt_o), 0);
      chk("rst_ext_gnt", -1, 32'(bus.ext_gnt_o), 0);
      chk("rst_mem_en", -1, 32'(bus.mem_en_o), 0);
      chk("rst_mem_we", -1, 32'(bus.mem_we_o), 0);
      chk("rst_cpu_stall", -1, 32'(bus.cpu_stall_o), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
               vecs[i].ereq, vecs[i].ewe, vecs[i].eaddr, vecs[i].ewd);
         #4;
         check_row(i);
         step();
      end

      // Sustained contention.
`ifdef MEM_ARB_STARVE_GUARD_EN
      for (int c = 1; c <= 9; c++) begin
         drive(1, 0, 32'h10, 0, 1, 0, 7, 0);
         #4;
         chk("starve_ext_gnt", c, 32'(bus.ext_gnt_o), (c == 9) ? 1 : 0);
         chk("starve_cpu_stall", c, 32'(bus.cpu_stall_o), (c == 9) ? 1 : 0);
         step();
      end
      drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
      #4;
      chk("starve_cleared_cpu_gnt", 10, 32'(bus.cpu_gnt_o), 1);
      step();
`else
      for (int c = 1; c <= 12; c++) begin
         drive(1, 0, 32'h10, 0, 1, 0, 7, 0);
         #4;
         chk("prio_cpu_gnt", c, 32'(bus.cpu_gnt_o), 1);
         chk("prio_ext_gnt", c, 32'(bus.ext_gnt_o), 0);
         step();
      end
`endif

      // Reset arriving the cycle after a granted ext read cancels its rvalid.
      drive(0, 0, 0, 0, 1, 0, 7, 0);
      #4;
      chk("pre_rst_ext_gnt", -2, 32'(bus.ext_gnt_o), 1);
      step();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      chk("mid_rst_ext_rvalid", -2, 32'(bus.ext_rvalid_o), 0);
      chk("mid_rst_ext_rdata", -2, bus.ext_rdata_o, 0);
      chk("mid_rst_mem_en", -2, 32'(bus.mem_en_o), 0);
      step();
      reset = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #4;
         chk("post_rst_ext_rvalid", c, 32'(bus.ext_rvalid_o), 0);
         chk("post_rst_cpu_rvalid", c, 32'(bus.cpu_rvalid_o), 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
